// File: rtl/side_buffer_pkg.sv
// Shared flit types and side-buffer defaults.
// Every side_buffer file imports this package.
package side_buffer_pkg;

   localparam int SB_DEPTH_DEF     = 4;
   localparam int SB_STARVE_TH_DEF = 8;

   typedef struct packed {
      logic        vld;
      logic [3:0]  dst;
      logic [15:0] data;
   } flit_int_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_STARVED
   } starve_state_e;

endpackage

// File: rtl/side_buffer_if.sv
// Flit, injection-handshake and status bundle of the side buffer.
// The buffer is the slave; the redirect/injection environment is the master.
interface side_buffer_if #(
   parameter int DEPTH = side_buffer_pkg::SB_DEPTH_DEF
);
   import side_buffer_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   flit_int_t        din;
   logic             inject_gnt;
   flit_int_t        dout;
   logic             full;
   logic             starve;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output din, inject_gnt,
      input  dout, full, starve, count, overflow
   );

   modport slave (
      input  din, inject_gnt,
      output dout, full, starve, count, overflow
   );

endinterface

// File: rtl/sb_fifo_mem.sv
// Flit register array with wrapping read/write pointers and occupancy count.
// The caller guarantees i_push/i_pop are only raised when legal.
module sb_fifo_mem
   import side_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  flit_int_t        i_din,
   output flit_int_t        o_head,
   output logic [CNT_W-1:0] o_count
);

   flit_int_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   // NOTE: storage has no reset; validity is tracked solely by r_count.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/side_buffer.sv
// Side buffer for redirected/deflected flits: FIFO storage plus a head-of-line
// starvation detector that raises starve after STARVE_TH blocked cycles.
module side_buffer
   import side_buffer_pkg::*;
#(
   parameter int DEPTH     = SB_DEPTH_DEF,
   parameter int STARVE_TH = SB_STARVE_TH_DEF
) (
   input logic         clk,
   input logic         rst_n,
   side_buffer_if.slave sb
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SC_W  = $clog2(STARVE_TH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [SC_W-1:0]  TH_C    = SC_W'(STARVE_TH);

   flit_int_t        w_head;
   flit_int_t        w_wr_flit;
   logic [CNT_W-1:0] w_count;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_empty_next;
   logic [SC_W-1:0]  r_starve_cnt;
   logic [SC_W-1:0]  w_starve_cnt_next;
   starve_state_e    r_state;
   starve_state_e    w_state_next;
   logic             r_overflow;

   assign w_empty = (w_count == '0);
   assign w_full  = (w_count == DEPTH_C);
   assign w_pop   = sb.inject_gnt && !w_empty;
   assign w_push  = sb.din.vld && (!w_full || w_pop);

   always_comb begin
      w_wr_flit     = sb.din;
      w_wr_flit.vld = 1'b1;
   end

   sb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_wr_flit),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign w_empty_next = (w_empty && !w_push) ||
                         ((w_count == CNT_W'(1)) && w_pop && !w_push);

   // NOTE: every combinational output gets a default first, so no latches form.
   always_comb begin
      w_starve_cnt_next = r_starve_cnt;
      w_state_next      = r_state;

      if (w_empty || w_pop) begin
         w_starve_cnt_next = '0;
      end else if (r_starve_cnt != TH_C) begin
         w_starve_cnt_next = r_starve_cnt + 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            if (!w_empty_next) w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_empty_next)                   w_state_next = ST_IDLE;
            else if (w_starve_cnt_next == TH_C) w_state_next = ST_STARVED;
         end
         ST_STARVED: begin
            if (w_empty_next) w_state_next = ST_IDLE;
            else if (w_pop)   w_state_next = ST_WAIT;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
         r_state      <= ST_IDLE;
         r_overflow   <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_cnt_next;
         r_state      <= w_state_next;
         if (sb.din.vld && !w_push) r_overflow <= 1'b1;
      end
   end

   assign sb.dout     = w_empty ? '0 : w_head;
   assign sb.full     = w_full;
   assign sb.starve   = (r_state == ST_STARVED);
   assign sb.count    = w_count;
   assign sb.overflow = r_overflow;

endmodule

// File: tb/tb_side_buffer.sv
// Directed bench for side_buffer (DEPTH=4, STARVE_TH=8); inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_side_buffer;
   import side_buffer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   side_buffer_if #(.DEPTH(4)) sb ();

   side_buffer #(.DEPTH(4), .STARVE_TH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb)
   );

   always #5 clk = ~clk;

   function automatic flit_int_t mk(input logic [15:0] d);
      flit_int_t f;
      f.vld  = 1'b1;
      f.dst  = d[3:0];
      f.data = d;
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sb.din        = '0;
      sb.inject_gnt = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++;
      if (sb.dout !== '0 || sb.full !== 1'b0 || sb.starve !== 1'b0 ||
          sb.count !== 3'd0 || sb.overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs dout=%h full=%b starve=%b count=%0d ovf=%b expected all 0",
                  sb.dout, sb.full, sb.starve, sb.count, sb.overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Four pushes, no grant: full after the 4th edge, starve 8 edges after the first push.
   task automatic test_fill_starve();
      for (int i = 1; i <= 4; i++) begin
         sb.din = mk(16'(i));
         step();
         checks++;
         if (sb.count !== 3'(i) || sb.dout.vld !== 1'b1 || sb.dout.data !== 16'd1) begin
            failures++;
            $display("FAIL fill_%0d count=%0d vld=%b head=%h expected count=%0d vld=1 head=1",
                     i, sb.count, sb.dout.vld, sb.dout.data, i);
         end
      end
      idle_inputs();
      checks++;
      if (sb.full !== 1'b1) begin
         failures++;
         $display("FAIL fill_full got=%b expected=1", sb.full);
      end
      repeat (4) step();
      checks++;
      if (sb.starve !== 1'b0) begin
         failures++;
         $display("FAIL starve_early got=%b expected=0 at 7 edges", sb.starve);
      end
      step();
      checks++;
      if (sb.starve !== 1'b1) begin
         failures++;
         $display("FAIL starve_assert got=%b expected=1 at 8 edges", sb.starve);
      end
      step();
      checks++;
      if (sb.starve !== 1'b1) begin
         failures++;
         $display("FAIL starve_saturate got=%b expected=1", sb.starve);
      end
   endtask

   task automatic test_full_push_pop();
      sb.din        = mk(16'd5);
      sb.inject_gnt = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (sb.count !== 3'd4 || sb.full !== 1'b1 || sb.overflow !== 1'b0 ||
          sb.dout.data !== 16'd2 || sb.starve !== 1'b0) begin
         failures++;
         $display("FAIL full_push_pop count=%0d full=%b ovf=%b head=%h starve=%b expected 4 1 0 0002 0",
                  sb.count, sb.full, sb.overflow, sb.dout.data, sb.starve);
      end
   endtask

   // Dropped push while full, then drain: 6 must never appear, order 2..5 kept.
   task automatic test_overflow();
      logic [15:0] exp_q [4] = '{16'd2, 16'd3, 16'd4, 16'd5};
      sb.din = mk(16'd6);
      step();
      idle_inputs();
      checks++;
      if (sb.overflow !== 1'b1 || sb.count !== 3'd4 || sb.dout.data !== 16'd2) begin
         failures++;
         $display("FAIL overflow_set ovf=%b count=%0d head=%h expected 1 4 0002",
                  sb.overflow, sb.count, sb.dout.data);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sb.dout.vld !== 1'b1 || sb.dout.data !== exp_q[i]) begin
            failures++;
            $display("FAIL drain_%0d vld=%b data=%h expected vld=1 data=%h",
                     i, sb.dout.vld, sb.dout.data, exp_q[i]);
         end
         sb.inject_gnt = 1'b1;
         step();
      end
      step();
      sb.inject_gnt = 1'b0;
      checks++;
      if (sb.count !== 3'd0 || sb.dout !== '0 || sb.overflow !== 1'b1 || sb.full !== 1'b0) begin
         failures++;
         $display("FAIL drain_empty count=%0d dout=%h ovf=%b full=%b expected 0 0 1 0",
                  sb.count, sb.dout, sb.overflow, sb.full);
      end
   endtask

   task automatic test_starve_release();
      do_reset();
      checks++;
      if (sb.overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_cleared got=%b expected=0", sb.overflow);
      end
      for (int i = 0; i < 4; i++) begin
         sb.din = mk(16'(16'h10 + i));
         step();
      end
      idle_inputs();
      repeat (5) step();
      checks++;
      if (sb.starve !== 1'b1) begin
         failures++;
         $display("FAIL release_pre got=%b expected=1", sb.starve);
      end
      sb.inject_gnt = 1'b1;
      step();
      sb.inject_gnt = 1'b0;
      checks++;
      if (sb.starve !== 1'b0 || sb.count !== 3'd3 || sb.dout.data !== 16'h11) begin
         failures++;
         $display("FAIL release_pop starve=%b count=%0d head=%h expected 0 3 0011",
                  sb.starve, sb.count, sb.dout.data);
      end
      repeat (7) step();
      checks++;
      if (sb.starve !== 1'b0) begin
         failures++;
         $display("FAIL restart_early got=%b expected=0", sb.starve);
      end
      step();
      checks++;
      if (sb.starve !== 1'b1) begin
         failures++;
         $display("FAIL restart_assert got=%b expected=1", sb.starve);
      end
   endtask

   // Entered with count=3 and starve=1; reset must clear outputs without a clock edge.
   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sb.dout !== '0 || sb.full !== 1'b0 || sb.starve !== 1'b0 ||
          sb.count !== 3'd0 || sb.overflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset dout=%h full=%b starve=%b count=%0d ovf=%b expected all 0",
                  sb.dout, sb.full, sb.starve, sb.count, sb.overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (sb.dout.vld !== 1'b0 || sb.count !== 3'd0) begin
         failures++;
         $display("FAIL post_reset vld=%b count=%0d expected 0 0", sb.dout.vld, sb.count);
      end
      sb.din = mk(16'h77);
      #1;
      checks++;
      if (sb.dout.vld !== 1'b0) begin
         failures++;
         $display("FAIL no_bypass vld=%b expected=0", sb.dout.vld);
      end
      step();
      idle_inputs();
      checks++;
      if (sb.dout.vld !== 1'b1 || sb.dout.data !== 16'h77) begin
         failures++;
         $display("FAIL push_visible vld=%b data=%h expected 1 0077", sb.dout.vld, sb.dout.data);
      end
   endtask

   // Ten flits through a queue model with interleaved pops, crossing the pointer wrap.
   task automatic test_wrap();
      logic [15:0] q [$];
      int          n = 0;
      int          cyc = 0;
      bit          pop;
      bit          push;
      do_reset();
      while ((n < 10 || q.size() > 0) && cyc < 60) begin
         checks++;
         if (q.size() == 0) begin
            if (sb.dout.vld !== 1'b0) begin
               failures++;
               $display("FAIL wrap_empty cyc=%0d vld=%b expected=0", cyc, sb.dout.vld);
            end
         end else if (sb.dout.vld !== 1'b1 || sb.dout.data !== q[0]) begin
            failures++;
            $display("FAIL wrap_head cyc=%0d vld=%b data=%h expected vld=1 data=%h",
                     cyc, sb.dout.vld, sb.dout.data, q[0]);
         end
         checks++;
         if (int'(sb.count) != q.size()) begin
            failures++;
            $display("FAIL wrap_count cyc=%0d got=%0d expected=%0d", cyc, sb.count, q.size());
         end
         pop  = (cyc % 2 == 1) && (q.size() > 0);
         push = (n < 10) && (cyc % 3 != 2) && (q.size() < 4 || pop);
         sb.inject_gnt = (cyc % 2 == 1);
         sb.din        = push ? mk(16'(16'h100 + n)) : '0;
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(16'(16'h100 + n));
            n++;
         end
         step();
         cyc++;
      end
      idle_inputs();
      checks++;
      if (cyc >= 60) begin
         failures++;
         $display("FAIL wrap_timeout cycles=%0d expected<60", cyc);
      end
      checks++;
      if (sb.count !== 3'd0 || sb.overflow !== 1'b0) begin
         failures++;
         $display("FAIL wrap_end count=%0d ovf=%b expected 0 0", sb.count, sb.overflow);
      end
   endtask

   initial begin
      test_reset();
      test_fill_starve();
      test_full_push_pop();
      test_overflow();
      test_starve_release();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/side_buffer.md
SIDE_BUFFER -- requirements
Module: side_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of flit entries; it is a power of two and at least 2.
REQ-002 Parameter STARVE_TH, default 8, sets the number of consecutive blocked head cycles before starve asserts; it is at least 1.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  flit_int_t  incoming flit (redirected or deflection-buffered); din.vld is the push request.
REQ-006 inject_gnt  input  1  injection stage consumed dout this cycle; it is meaningful only while dout.vld=1.
REQ-007 dout  output  flit_int_t  head entry, combinational from storage; dout.vld=1 iff the buffer is non-empty.
REQ-008 full  output  1  count==DEPTH; feeds the redirect stage's full.
REQ-009 starve  output  1  registered starvation flag; feeds the redirect stage's starve.
REQ-010 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-011 overflow  output  1  sticky error: a push was dropped.

Function
REQ-012 Pop: occurs when inject_gnt && dout.vld; the head advances one entry at the edge.
REQ-013 Push: accepted when din.vld && (count<DEPTH || pop); din is written at the tail with vld forced to 1.
REQ-014 Simultaneous push and pop: count is unchanged, and full stays asserted if it was asserted.
REQ-015 Push while full without pop: din is dropped, the storage is unchanged, and overflow is set to 1 until reset.
REQ-016 inject_gnt with an empty buffer is ignored: no pointer movement, and count stays at 0.
REQ-017 Pointer widths: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is separate.
REQ-018 Ordering: strict FIFO.
REQ-019 The zero-cycle latency path from push to dout is forbidden; a flit pushed into an empty buffer appears on dout the next cycle.
REQ-020 starve counter, width $clog2(STARVE_TH+1):
  - reset to 0 on a pop or while empty;
  - incremented each cycle dout.vld && !inject_gnt;
  - saturates at STARVE_TH.
REQ-021 starve is registered and is 1 exactly when the counter equals STARVE_TH.
REQ-022 starve deasserts on the edge following the pop that clears the counter.
REQ-023 States of the starve logic:
  - IDLE (empty);
  - WAIT (non-empty, counter<STARVE_TH);
  - STARVED (counter==STARVE_TH).
  Transitions: WAIT->STARVED on saturation; any state->IDLE when empty; STARVED->WAIT on pop with remaining entries.
REQ-024 dout content when empty: all fields 0.

Reset
REQ-025 rst_n low asynchronously clears pointers, count, the starve counter, starve and overflow.
REQ-026 Reset outputs: dout.vld=0, full=0, starve=0, count=0, overflow=0.
REQ-027 Storage contents are not reset.
REQ-028 Reset asserted mid-operation discards all buffered flits; the first cycle after deassertion behaves as empty.

Structure
REQ-029 flit_int_t and the DEPTH and STARVE_TH defaults come from the shared flit/global package; no local redefinition.
REQ-030 A single sub-module, sb_fifo_mem (register array plus pointers), is instantiated; the starve logic stays in side_buffer.
REQ-031 No combinational path exists from din to full or starve.

Verification
REQ-032 Reset, then 4 pushes with no inject_gnt: count=4 and full=1 after the 4th edge; starve=1 exactly 8 cycles after the first push became visible.
REQ-033 Buffer full, push and inject_gnt in the same cycle: count stays 4, FIFO order is preserved, overflow=0.
REQ-034 Buffer full, push without inject_gnt: overflow=1 and stays 1; the pushed flit never appears on dout.
REQ-035 Starve reached, then one inject_gnt with 3 entries left: starve=0 on the next edge and the counter restarts from 0.
REQ-036 Push 10 flits with interleaved pops across a pointer wrap: output order equals input order and count never exceeds 4.
REQ-037 Assert rst_n low while count=3 and starve=1: all outputs are 0 immediately, without waiting for a clock edge.
